// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: collects WIDTH serial bits in either
// bit order and hands the finished word to a registered valid/ready slot.
module sipo_deser #(
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       msb_first_i,
  input  logic                       sdata_i,
  input  logic                       sbit_vld_i,
  input  logic                       pready_i,
  input  logic                       clr_i,
  output logic [WIDTH-1:0]           pdata_o,
  output logic                       pvalid_o,
  output logic                       busy_o,
  output logic [$clog2(WIDTH+1)-1:0] cnt_o,
  output logic                       overrun_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx, shifted, pdata_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             mode, mode_nx;
  logic             pvalid_nx, overrun_nx, complete;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      mode      <= 1'b0;
      pdata_o   <= '0;
      pvalid_o  <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state     <= state_nx;
      sreg      <= sreg_nx;
      cnt       <= cnt_nx;
      mode      <= mode_nx;
      pdata_o   <= pdata_nx;
      pvalid_o  <= pvalid_nx;
      overrun_o <= overrun_nx;
    end
  end

  // Frame assembly; start_i wins over a bit arriving in the same cycle.
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    mode_nx  = mode;
    complete = 1'b0;
    shifted  = mode ? {sreg[WIDTH-2:0], sdata_i} : {sdata_i, sreg[WIDTH-1:1]};
    if (start_i) begin
      state_nx = SHIFT;
      sreg_nx  = '0;
      cnt_nx   = '0;
      mode_nx  = msb_first_i;
    end else if (state == SHIFT && sbit_vld_i) begin
      sreg_nx = shifted;
      if (cnt == LAST_IDX) begin
        complete = 1'b1;
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  // Output slot: a completed word may land in the same edge the old one drains.
  always_comb begin
    pdata_nx   = pdata_o;
    pvalid_nx  = pvalid_o;
    overrun_nx = overrun_o;
    if (pvalid_o && pready_i) begin
      pvalid_nx = 1'b0;
    end
    if (clr_i) begin
      overrun_nx = 1'b0;
    end
    if (complete) begin
      if (!pvalid_o || pready_i) begin
        pdata_nx  = shifted;
        pvalid_nx = 1'b1;
      end else begin
        overrun_nx = 1'b1;
      end
    end
  end

  assign busy_o = (state == SHIFT);
  assign cnt_o  = cnt;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed scenarios plus a randomized run
// compared cycle by cycle against a bit-queue reference model.
module tb_sipo_deser;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          rst_i, start_i, msb_first_i, sdata_i, sbit_vld_i, pready_i, clr_i;
  logic [W-1:0]  pdata_o;
  logic          pvalid_o, busy_o, overrun_o;
  logic [CW-1:0] cnt_o;

  int n_compared   = 0;
  int n_mismatched = 0;
  int rise_cnt     = 0;
  logic prev_valid = 1'b0;

  // Reference model: collected bits kept in a queue, word built at completion.
  bit           m_busy, m_msb, m_pvalid, m_overrun;
  logic [W-1:0] m_pdata;
  bit           m_bits[$];

  sipo_deser #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .msb_first_i(msb_first_i),
    .sdata_i(sdata_i), .sbit_vld_i(sbit_vld_i), .pready_i(pready_i), .clr_i(clr_i),
    .pdata_o(pdata_o), .pvalid_o(pvalid_o), .busy_o(busy_o), .cnt_o(cnt_o),
    .overrun_o(overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pvalid_o && !prev_valid) rise_cnt++;
    prev_valid = pvalid_o;
  end

  function automatic logic [W-1:0] assemble();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (m_msb) w[W-1-i] = m_bits[i];
      else       w[i]     = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_update();
    bit           comp, ov, old_valid;
    logic [W-1:0] w;
    comp = 0; ov = 0; w = '0;
    old_valid = m_pvalid;
    if (rst_i) begin
      m_busy = 0; m_msb = 0; m_pvalid = 0; m_overrun = 0; m_pdata = '0;
      m_bits.delete();
    end else begin
      if (start_i) begin
        m_busy = 1; m_msb = msb_first_i; m_bits.delete();
      end else if (m_busy && sbit_vld_i) begin
        m_bits.push_back(sdata_i);
        if (m_bits.size() == W) begin
          w = assemble(); comp = 1; m_busy = 0; m_bits.delete();
        end
      end
      if (old_valid && pready_i) m_pvalid = 0;
      if (comp) begin
        if (!old_valid || pready_i) begin
          m_pdata = w; m_pvalid = 1;
        end else begin
          ov = 1;
        end
      end
      if (clr_i) m_overrun = 0;
      if (ov)    m_overrun = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst_i = 0; start_i = 0; msb_first_i = 0; sdata_i = 0;
    sbit_vld_i = 0; pready_i = 0; clr_i = 0;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input bit msb, input int gap,
                           input bit ready_last);
    for (int i = 0; i < W; i++) begin
      sbit_vld_i = 1;
      sdata_i    = msb ? w[W-1-i] : w[i];
      if (i == W - 1) pready_i = ready_last;
      step();
      sbit_vld_i = 0;
      pready_i   = 0;
      for (int g = 0; g < gap; g++) step();
    end
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit msb, input bit ready_last);
    start_i = 1; msb_first_i = msb;
    step();
    start_i = 0;
    send_bits(w, msb, 0, ready_last);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1;
    step(); step();
    rst_i = 0;
    n_compared++;
    if ({pdata_o, pvalid_o, busy_o, cnt_o, overrun_o} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got pdata=%h pvalid=%b busy=%b cnt=%0d ovr=%b, want all 0",
               pdata_o, pvalid_o, busy_o, cnt_o, overrun_o);
    end
  endtask

  task automatic test_lsb_first();
    send_frame(8'hA5, 0, 0);
    n_compared++;
    if ({pdata_o, pvalid_o, busy_o, cnt_o, overrun_o} !== {8'hA5, 1'b1, 1'b0, 4'd0, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL lsb_first: got pdata=%h pvalid=%b busy=%b cnt=%0d ovr=%b, want a5 1 0 0 0",
               pdata_o, pvalid_o, busy_o, cnt_o, overrun_o);
    end
  endtask

  task automatic test_msb_gaps();
    logic [W-1:0] w = 8'h3C;
    pready_i = 1; step(); pready_i = 0;
    start_i = 1; msb_first_i = 1; step(); start_i = 0;
    for (int i = 0; i < W; i++) begin
      sbit_vld_i = 1; sdata_i = w[W-1-i]; step(); sbit_vld_i = 0;
      if (i < W - 1) begin
        n_compared++;
        if (busy_o !== 1'b1 || cnt_o !== CW'(i + 1)) begin
          n_mismatched++;
          $display("[TB] FAIL msb_count: got busy=%b cnt=%0d, want busy=1 cnt=%0d", busy_o, cnt_o, i + 1);
        end
        step(); step();
        n_compared++;
        if (busy_o !== 1'b1 || cnt_o !== CW'(i + 1)) begin
          n_mismatched++;
          $display("[TB] FAIL msb_gap_hold: got busy=%b cnt=%0d, want busy=1 cnt=%0d", busy_o, cnt_o, i + 1);
        end
      end
    end
    n_compared++;
    if (pdata_o !== 8'h3C || pvalid_o !== 1'b1 || busy_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL msb_word: got pdata=%h pvalid=%b busy=%b, want 3c 1 0", pdata_o, pvalid_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    pready_i = 1; step(); pready_i = 0;
    send_frame(8'h11, 0, 0);
    send_frame(8'h22, 0, 0);
    n_compared++;
    if (pdata_o !== 8'h11 || pvalid_o !== 1'b1 || overrun_o !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL overrun: got pdata=%h pvalid=%b ovr=%b, want 11 1 1", pdata_o, pvalid_o, overrun_o);
    end
    pready_i = 1; step(); pready_i = 0;
    n_compared++;
    if (pvalid_o !== 1'b0 || overrun_o !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL drain: got pvalid=%b ovr=%b, want 0 1", pvalid_o, overrun_o);
    end
    clr_i = 1; step(); clr_i = 0;
    n_compared++;
    if (overrun_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL overrun_clear: got ovr=%b, want 0", overrun_o);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 0, 0);
    send_frame(8'h22, 0, 1);
    n_compared++;
    if (pdata_o !== 8'h22 || pvalid_o !== 1'b1 || overrun_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL collision: got pdata=%h pvalid=%b ovr=%b, want 22 1 0", pdata_o, pvalid_o, overrun_o);
    end
    pready_i = 1; step(); pready_i = 0;
  endtask

  task automatic test_abort();
    int rises0;
    rises0 = rise_cnt;
    start_i = 1; msb_first_i = 0; step(); start_i = 0;
    for (int i = 0; i < 4; i++) begin
      sbit_vld_i = 1; sdata_i = 1'(i); step();
    end
    start_i = 1; sbit_vld_i = 1; sdata_i = 1; step();
    start_i = 0; sbit_vld_i = 0;
    send_bits(8'h5A, 0, 0, 0);
    step();
    n_compared++;
    if (pdata_o !== 8'h5A || pvalid_o !== 1'b1 || rise_cnt - rises0 !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL abort: got pdata=%h pvalid=%b rises=%0d, want 5a 1 1",
               pdata_o, pvalid_o, rise_cnt - rises0);
    end
  endtask

  task automatic test_reset_midframe();
    start_i = 1; msb_first_i = 1; step(); start_i = 0;
    for (int i = 0; i < 5; i++) begin
      sbit_vld_i = 1; sdata_i = 1; step();
    end
    sbit_vld_i = 0;
    rst_i = 1; step(); rst_i = 0;
    n_compared++;
    if ({pdata_o, pvalid_o, busy_o, cnt_o, overrun_o} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_midframe: got pdata=%h pvalid=%b busy=%b cnt=%0d ovr=%b, want all 0",
               pdata_o, pvalid_o, busy_o, cnt_o, overrun_o);
    end
    send_frame(8'hC3, 1, 0);
    n_compared++;
    if (pdata_o !== 8'hC3 || pvalid_o !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_frame: got pdata=%h pvalid=%b, want c3 1", pdata_o, pvalid_o);
    end
  endtask

  task automatic test_random();
    logic [CW-1:0] m_cnt;
    for (int c = 0; c < 600; c++) begin
      rst_i       = ($urandom_range(0, 99) == 0);
      start_i     = ($urandom_range(0, 19) == 0);
      msb_first_i = 1'($urandom);
      sdata_i     = 1'($urandom);
      sbit_vld_i  = ($urandom_range(0, 2) != 0);
      pready_i    = ($urandom_range(0, 3) == 0);
      clr_i       = ($urandom_range(0, 15) == 0);
      step();
      m_cnt = CW'(m_bits.size());
      n_compared++;
      if ({pdata_o, pvalid_o, busy_o, cnt_o, overrun_o} !==
          {m_pdata, m_pvalid, m_busy, m_cnt, m_overrun}) begin
        n_mismatched++;
        $display("[TB] FAIL random_cycle%0d: got pdata=%h pvalid=%b busy=%b cnt=%0d ovr=%b, want %h %b %b %0d %b",
                 c, pdata_o, pvalid_o, busy_o, cnt_o, overrun_o,
                 m_pdata, m_pvalid, m_busy, m_cnt, m_overrun);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_lsb_first();
    test_msb_gaps();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in/parallel-out deserializer: the receive end of the team's universal shift register transmit path.
- Accepts one serial bit per qualified cycle, in either LSB-first (right-shift) or MSB-first (left-shift) order.
- Assembles a WIDTH-bit word and presents it on a registered valid/ready output port.
- Sits between a serial link, driven by a stage-chain shift register in shift mode, and a parallel consumer.

Parameters:
- WIDTH, 8, word length in bits; must be >= 2.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  frame start; aborts any frame in progress.
- msb_first_i  input  1  bit order, sampled on start_i: 1 = MSB first (left shift), 0 = LSB first (right shift).
- sdata_i  input  1  serial data bit.
- sbit_vld_i  input  1  sdata_i is valid this cycle.
- pready_i  input  1  consumer accepts pdata_o.
- clr_i  input  1  clears overrun_o.
- pdata_o  output  WIDTH  assembled parallel word.
- pvalid_o  output  1  pdata_o holds an unconsumed word.
- busy_o  output  1  frame in progress (state SHIFT).
- cnt_o  output  clog2(WIDTH+1)  bits received in the current frame.
- overrun_o  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (rst_i=1 at an edge) overrides every other input. Result:
  - state IDLE;
  - shift register, pdata_o, pvalid_o, cnt_o, overrun_o, busy_o and mode register all 0.
- Reset mid-frame discards the partial word and any pending output word.
- State IDLE (busy_o=0):
  - sbit_vld_i is ignored.
  - start_i=1: go to SHIFT, clear the shift register, cnt_o=0, latch msb_first_i into the mode register.
  - A bit presented in the start_i cycle is not sampled.
- State SHIFT (busy_o=1), for each cycle with sbit_vld_i=1:
  - MSB-first: sreg <= {sreg[WIDTH-2:0], sdata_i}.
  - LSB-first: sreg <= {sdata_i, sreg[WIDTH-1:1]}.
  - cnt_o increments.
- Cycles with sbit_vld_i=0 hold all state. Gaps of any length are allowed.
- Word completion: sbit_vld_i=1 while cnt_o == WIDTH-1.
  - The completed word is the post-shift value.
  - State returns to IDLE and cnt_o returns to 0 at the same edge.
- Output load at completion:
  - The word is loaded if the output slot is empty (pvalid_o=0) or draining this cycle (pvalid_o=1 and pready_i=1).
  - On load, pdata_o takes the word and pvalid_o=1 at the same edge that sampled the final bit. Latency is 0 cycles after the last bit edge.
  - With drain and load in the same cycle, pvalid_o stays 1, pdata_o changes to the new word, and no overrun occurs.
- Overrun: completion while pvalid_o=1 and pready_i=0.
  - The new word is dropped and pdata_o is unchanged.
  - overrun_o is set to 1.
- Output handshake:
  - Transfer occurs on an edge with pvalid_o=1 and pready_i=1. pvalid_o then clears unless a load occurs the same edge.
  - pdata_o is stable while pvalid_o=1 and not transferring.
  - pready_i while pvalid_o=0 has no effect.
- start_i while in SHIFT:
  - Restarts the frame: the shift register is cleared, cnt_o=0, and the mode is relatched.
  - start_i has priority over a simultaneous sbit_vld_i; that bit is dropped.
  - The output slot is unaffected.
- overrun_o stays set until clr_i=1. If set and clear coincide, set wins.
- sdata_i is don't-care when sbit_vld_i=0.

Test Plan:
- LSB-first, WIDTH=8: start_i with msb_first_i=0, then bits 1,0,1,0,0,1,0,1 on consecutive cycles, pready_i=0 -> pvalid_o=1 and pdata_o=0xA5 at the edge of the 8th bit; busy_o=0 and cnt_o=0 after; overrun_o=0.
- MSB-first: start_i with msb_first_i=1, then bits 0,0,1,1,1,1,0,0 with sbit_vld_i asserted only every 3rd cycle -> busy_o=1 throughout the frame, cnt_o steps 1..7, pdata_o=0x3C, pvalid_o=1.
- Backpressure, LSB-first, pready_i=0: frame 0x11 then frame 0x22 -> pdata_o stays 0x11 and overrun_o=1. Then pready_i=1 for one cycle -> pvalid_o=0. Then clr_i=1 -> overrun_o=0.
- Drain/load collision: pvalid_o=1 with 0x11 held; raise pready_i in the same cycle as the final bit of frame 0x22 -> pvalid_o stays 1, pdata_o=0x22, overrun_o=0.
- Abort: start_i, 4 bits, then start_i together with sbit_vld_i=1, then 8 bits of 0x5A LSB-first -> exactly one pvalid_o rise, pdata_o=0x5A.
- Reset mid-frame: rst_i=1 after 5 bits with a pending word in pdata_o -> next cycle all outputs 0 and state IDLE. A following full frame of 0xC3 -> pdata_o=0xC3, pvalid_o=1.
